password_judge: RTL



---
 rtl/lock_pkg.sv | 25 ++
 rtl/password_judge_if.sv | 28 ++
 rtl/entry_buffer.sv | 47 ++++
 rtl/password_judge.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared definitions for the six-digit lock: key codes, password geometry
// and the judge FSM state encoding.
package lock_pkg;

    localparam int PWD_DIGITS = 6;
    localparam int DIGIT_W    = 4;
    localparam logic [23:0] DEFAULT_PWD = 24'h123456;

    localparam logic [3:0] KEY_CONFIRM = 4'hA;
    localparam logic [3:0] KEY_CLEAR   = 4'hB;
    localparam logic [3:0] KEY_SET     = 4'hC;
    localparam logic [3:0] KEY_LOCK    = 4'hD;

    typedef logic [1:0] state_t;

    localparam state_t ST_ENTRY    = 2'd0;
    localparam state_t ST_JUDGE    = 2'd1;
    localparam state_t ST_UNLOCKED = 2'd2;
    localparam state_t ST_SET      = 2'd3;

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'h9);
    endfunction

endpackage

// File: rtl/password_judge_if.sv
// Keypad / judge bundle between the lock front end and its surroundings.
interface password_judge_if #(
    parameter int DIGITS  = 6,
    parameter int DIGIT_W = 4
);
    localparam int CNT_W = $clog2(DIGITS + 1);

    logic                        key_valid;
    logic [DIGIT_W-1:0]          key_code;
    logic                        lockout;
    logic                        j;
    logic                        correct;
    logic                        unlocked;
    logic                        set_mode;
    logic [CNT_W-1:0]            digit_count;
    logic [DIGITS*DIGIT_W-1:0]   entry_buf;

    modport master (
        output key_valid, key_code, lockout,
        input  j, correct, unlocked, set_mode, digit_count, entry_buf
    );

    modport slave (
        input  key_valid, key_code, lockout,
        output j, correct, unlocked, set_mode, digit_count, entry_buf
    );

endinterface

// File: rtl/entry_buffer.sv
// Digit entry shift register with saturating count; newest digit sits in the
// low nibble. shift_out drops the newest digit (backspace).
module entry_buffer #(
    parameter int DIGITS  = 6,
    parameter int DIGIT_W = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              shift_in,
    input  logic                              shift_out,
    input  logic                              clear,
    input  logic [DIGIT_W-1:0]                digit,
    output logic [DIGITS*DIGIT_W-1:0]         entry_buf,
    output logic [$clog2(DIGITS+1)-1:0]       digit_count,
    output logic                              full
);
    localparam int PWD_W = DIGITS * DIGIT_W;
    localparam int CNT_W = $clog2(DIGITS + 1);

    logic [PWD_W-1:0] entry_r;
    logic [CNT_W-1:0] count_r;

    assign full        = (count_r == CNT_W'(DIGITS));
    assign entry_buf   = entry_r;
    assign digit_count = count_r;

    // Buffer update: clear wins, a full buffer ignores further digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_r <= {PWD_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            entry_r <= {PWD_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (shift_in && !full) begin
            entry_r <= {entry_r[PWD_W-DIGIT_W-1:0], digit};
            count_r <= count_r + CNT_W'(1);
        end else if (shift_out && (count_r != {CNT_W{1'b0}})) begin
            entry_r <= {{DIGIT_W{1'b0}}, entry_r[PWD_W-1:DIGIT_W]};
            count_r <= count_r - CNT_W'(1);
        end else begin
            entry_r <= entry_r;
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/password_judge.sv
// Lock front end: collects keypad digits, judges them against the stored
// password and manages unlock / password-change. Optional macro BACKSPACE_EN
// turns the clear key into a single-digit backspace.
module password_judge #(
    parameter int DIGITS  = lock_pkg::PWD_DIGITS,
    parameter int DIGIT_W = lock_pkg::DIGIT_W,
    parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_PWD = lock_pkg::DEFAULT_PWD
) (
    input logic              clk,
    input logic              rst_n,
    password_judge_if.slave  bus
);
    import lock_pkg::*;

    localparam int PWD_W = DIGITS * DIGIT_W;
    localparam int CNT_W = $clog2(DIGITS + 1);

    state_t           state_r;
    state_t           state_s;
    logic [PWD_W-1:0] stored_r;
    logic             j_r;
    logic             correct_r;
    logic             unlocked_r;
    logic             set_mode_r;

    logic             shift_in_s;
    logic             shift_out_s;
    logic             clear_s;
    logic             erase_clear_s;
    logic             store_s;
    logic             match_s;
    logic             full_s;
    logic             edit_en_s;
    logic             key_digit_s;
    logic             key_erase_s;
    logic             key_confirm_s;
    logic             key_set_s;
    logic             key_lock_s;
    logic [PWD_W-1:0] entry_s;
    logic [CNT_W-1:0] count_s;

    entry_buffer #(
        .DIGITS  (DIGITS),
        .DIGIT_W (DIGIT_W)
    ) u_entry_buffer (
        .clk         (clk),
        .rst_n       (rst_n),
        .shift_in    (shift_in_s),
        .shift_out   (shift_out_s),
        .clear       (clear_s),
        .digit       (bus.key_code),
        .entry_buf   (entry_s),
        .digit_count (count_s),
        .full        (full_s)
    );

    assign key_digit_s   = bus.key_valid && is_digit(bus.key_code);
    assign key_erase_s   = bus.key_valid && (bus.key_code == KEY_CLEAR);
    assign key_confirm_s = bus.key_valid && (bus.key_code == KEY_CONFIRM);
    assign key_set_s     = bus.key_valid && (bus.key_code == KEY_SET);
    assign key_lock_s    = bus.key_valid && (bus.key_code == KEY_LOCK);

    // Editing keys only count in ENTRY (not locked out) and in SET.
    assign edit_en_s  = ((state_r == ST_ENTRY) && !bus.lockout) || (state_r == ST_SET);
    assign shift_in_s = edit_en_s && key_digit_s;
    assign match_s    = full_s && (entry_s == stored_r);

`ifdef BACKSPACE_EN
    assign shift_out_s   = edit_en_s && key_erase_s;
    assign erase_clear_s = 1'b0;
`else
    assign shift_out_s   = 1'b0;
    assign erase_clear_s = edit_en_s && key_erase_s;
`endif

    // Next-state, buffer-clear and password-store decisions.
    always_comb begin
        state_s = state_r;
        clear_s = erase_clear_s;
        store_s = 1'b0;
        case (state_r)
            ST_ENTRY: begin
                if (bus.lockout) begin
                    clear_s = 1'b1;
                end else if (key_confirm_s) begin
                    state_s = ST_JUDGE;
                end else begin
                    state_s = ST_ENTRY;
                end
            end
            ST_JUDGE: begin
                clear_s = 1'b1;
                if (match_s) begin
                    state_s = ST_UNLOCKED;
                end else begin
                    state_s = ST_ENTRY;
                end
            end
            ST_UNLOCKED: begin
                if (key_lock_s) begin
                    state_s = ST_ENTRY;
                end else if (key_set_s) begin
                    state_s = ST_SET;
                    clear_s = 1'b1;
                end else begin
                    state_s = ST_UNLOCKED;
                end
            end
            ST_SET: begin
                if (key_confirm_s) begin
                    store_s = full_s;
                    clear_s = 1'b1;
                    state_s = ST_UNLOCKED;
                end else if (key_lock_s) begin
                    clear_s = 1'b1;
                    state_s = ST_ENTRY;
                end else begin
                    state_s = ST_SET;
                end
            end
            default: begin
                clear_s = 1'b1;
                state_s = ST_ENTRY;
            end
        endcase
    end

    // State, stored password and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_ENTRY;
            stored_r   <= DEFAULT_PWD;
            j_r        <= 1'b0;
            correct_r  <= 1'b0;
            unlocked_r <= 1'b0;
            set_mode_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            if (store_s) begin
                stored_r <= entry_s;
            end
            j_r        <= (state_r == ST_JUDGE);
            correct_r  <= (state_r == ST_JUDGE) && match_s;
            unlocked_r <= (state_s == ST_UNLOCKED) || (state_s == ST_SET);
            set_mode_r <= (state_s == ST_SET);
        end
    end

    assign bus.j           = j_r;
    assign bus.correct     = correct_r;
    assign bus.unlocked    = unlocked_r;
    assign bus.set_mode    = set_mode_r;
    assign bus.digit_count = count_s;
    assign bus.entry_buf   = entry_s;

endmodule
